// File: rtl/obstacle_lane_scroller_if.sv
// ---------------------------------------------------------------------------
// obstacle_lane_scroller_if
//   Bundles the frame-tick controls and the playfield outputs of the obstacle
//   lane scroller so the draw and collision logic see one bus.
//
//   Controls (master -> slave):
//     update      one-cycle frame tick
//     pause       freeze all lane state
//     speed       requested scroll speed, step = speed + 1
//   Playfield (slave -> master):
//     x_flat      lane i x coordinate at [i*X_W +: X_W]
//     shape_flat  lane i shape code at [2i +: 2]
//     active      lane i obstacle on screen
//     spawn       one-cycle pulse when lane i spawns
//     exit_pulse  one-cycle pulse when lane i leaves the left edge
//     level       current speed-ramp level (0 when the ramp is not built)
// ---------------------------------------------------------------------------
interface obstacle_lane_scroller_if #(
  parameter int NUM_LANES = 3,
  parameter int X_W       = 8,
  parameter int SPEED_W   = 2
);
  logic                     update;
  logic                     pause;
  logic [SPEED_W-1:0]       speed;
  logic [NUM_LANES*X_W-1:0] x_flat;
  logic [NUM_LANES*2-1:0]   shape_flat;
  logic [NUM_LANES-1:0]     active;
  logic [NUM_LANES-1:0]     spawn;
  logic [NUM_LANES-1:0]     exit_pulse;
  logic [SPEED_W-1:0]       level;

  modport master (
    output update, pause, speed,
    input  x_flat, shape_flat, active, spawn, exit_pulse, level
  );

  modport slave (
    input  update, pause, speed,
    output x_flat, shape_flat, active, spawn, exit_pulse, level
  );
endinterface

// File: rtl/obstacle_lane_scroller.sv
// ---------------------------------------------------------------------------
// obstacle_lane_scroller
//   Multi-lane obstacle generator for the running-man playfield. Every lane
//   owns one obstacle that scrolls left by (speed+1) per frame tick. When it
//   leaves the left edge the lane waits a pseudo-random number of ticks and
//   then respawns at the right edge with a pseudo-random shape. A 16-bit
//   Fibonacci LFSR (taps 16,14,13,11) free-runs every non-reset cycle and
//   supplies both the shape codes and the respawn delays.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  synchronous, active-high, highest priority
//     bus    obstacle_lane_scroller_if.slave (update/pause/speed in,
//            x_flat/shape_flat/active/spawn/exit_pulse/level out)
//
//   Optional feature (macro OBSTACLE_SPEED_RAMP_EN):
//     counts exits, and every RAMP_COUNT exits raises `level` (saturating).
//     The effective speed becomes max(speed, level). Without the macro no
//     ramp logic is built and level is tied to 0.
// ---------------------------------------------------------------------------
module obstacle_lane_scroller #(
  parameter int          NUM_LANES  = 3,
  parameter int          X_W        = 8,
  parameter int          X_START    = 156,
  parameter int          X_MIN      = 4,
  parameter int          SPEED_W    = 2,
  parameter int          DLY_W      = 3,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          RAMP_COUNT = 8
) (
  input logic                    clk,
  input logic                    reset,
  obstacle_lane_scroller_if.slave bus
);

  localparam logic [X_W-1:0] X_START_C = X_W'(X_START);
  localparam logic [X_W-1:0] X_MIN_C   = X_W'(X_MIN);

  // Elaboration-time guard on the parameter ranges the design supports.
  if (NUM_LANES < 1 || NUM_LANES > 8 || RAMP_COUNT < 1 || SEED == 16'h0000 ||
      X_W <= SPEED_W) begin : g_param_check
    $error("obstacle_lane_scroller: unsupported parameter combination");
  end

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} lane_state_e;

  // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10), shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Respawn delay: low DLY_W bits of the LFSR rotated right by 4*lane.
  function automatic logic [DLY_W-1:0] dly_from(input logic [15:0] v, input int lane);
    int          r;
    logic [15:0] rot;
    r   = (4 * lane) % 16;
    rot = (v >> r) | (v << ((16 - r) % 16));
    return rot[DLY_W-1:0];
  endfunction

  // Shape code: two LFSR bits picked per lane so lanes decorrelate.
  function automatic logic [1:0] shape_from(input logic [15:0] v, input int lane);
    return {v[(3 * lane + 1) % 16], v[(3 * lane) % 16]};
  endfunction

  // Leftward step with saturation at X_MIN. The difference is formed two bits
  // wider than x and signed so a large step never wraps to a large x.
  function automatic logic [X_W-1:0] sat_step(input logic [X_W-1:0] x,
                                               input logic [SPEED_W:0] step);
    logic signed [X_W+1:0] diff;
    diff = $signed({2'b00, x}) - $signed({{(X_W + 1 - SPEED_W){1'b0}}, step});
    if (diff < $signed({2'b00, X_MIN_C})) begin
      return X_MIN_C;
    end
    return diff[X_W-1:0];
  endfunction

  lane_state_e          state_p1 [NUM_LANES];
  logic [DLY_W-1:0]     dly_p1   [NUM_LANES];
  logic [X_W-1:0]       x_p1     [NUM_LANES];
  logic [1:0]           shape_p1 [NUM_LANES];
  logic [NUM_LANES-1:0] active_p1;
  logic [NUM_LANES-1:0] spawn_p1;
  logic [NUM_LANES-1:0] exit_p1;
  logic [15:0]          lfsr_p1;

  logic                 tick_p0;
  logic [NUM_LANES-1:0] spawn_p0;
  logic [NUM_LANES-1:0] exit_p0;
  logic [SPEED_W-1:0]   eff_speed_p0;
  logic [SPEED_W:0]     step_p0;

  // ---- stage p0: tick qualification and per-lane event decode ----
  always_comb begin
    tick_p0  = bus.update & ~bus.pause;
    spawn_p0 = '0;
    exit_p0  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      spawn_p0[i] = tick_p0 && (state_p1[i] == HOLD) && (dly_p1[i] == '0);
      exit_p0[i]  = tick_p0 && (state_p1[i] == RUN) && (x_p1[i] <= X_MIN_C);
    end
  end

`ifdef OBSTACLE_SPEED_RAMP_EN
  // Exit counter wide enough to hold the pre-wrap sum of one tick's exits.
  localparam int CNT_W = $clog2(RAMP_COUNT + NUM_LANES + 1);

  logic [CNT_W-1:0]   ramp_cnt_p1;
  logic [CNT_W-1:0]   exit_sum_p0;
  logic [SPEED_W-1:0] level_p1;

  always_comb begin
    exit_sum_p0 = ramp_cnt_p1;
    for (int i = 0; i < NUM_LANES; i++) begin
      exit_sum_p0 = exit_sum_p0 + CNT_W'(exit_p0[i]);
    end
  end

  // ---- stage p1: ramp counter and level ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt_p1 <= '0;
      level_p1    <= '0;
    end else if (exit_sum_p0 >= CNT_W'(RAMP_COUNT)) begin
      ramp_cnt_p1 <= exit_sum_p0 - CNT_W'(RAMP_COUNT);
      if (level_p1 != '1) begin
        level_p1 <= level_p1 + SPEED_W'(1);
      end
    end else begin
      ramp_cnt_p1 <= exit_sum_p0;
    end
  end

  assign eff_speed_p0 = (bus.speed > level_p1) ? bus.speed : level_p1;
  assign bus.level    = level_p1;
`else
  assign eff_speed_p0 = bus.speed;
  assign bus.level    = '0;
`endif

  assign step_p0 = {1'b0, eff_speed_p0} + (SPEED_W + 1)'(1);

  // ---- stage p1: LFSR, lane FSMs and registered pulses ----
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_p1   <= SEED;
      active_p1 <= '0;
      spawn_p1  <= '0;
      exit_p1   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        state_p1[i] <= HOLD;
        dly_p1[i]   <= DLY_W'(i);
        x_p1[i]     <= X_START_C;
        shape_p1[i] <= 2'b00;
      end
    end else begin
      lfsr_p1  <= lfsr_next(lfsr_p1);
      spawn_p1 <= spawn_p0;
      exit_p1  <= exit_p0;
      if (tick_p0) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          case (state_p1[i])
            HOLD: begin
              if (spawn_p0[i]) begin
                state_p1[i]  <= RUN;
                x_p1[i]      <= X_START_C;
                active_p1[i] <= 1'b1;
                shape_p1[i]  <= shape_from(lfsr_p1, i);
              end else begin
                dly_p1[i] <= dly_p1[i] - DLY_W'(1);
              end
            end
            RUN: begin
              if (exit_p0[i]) begin
                // x stays at its last value while the lane idles.
                state_p1[i]  <= HOLD;
                active_p1[i] <= 1'b0;
                dly_p1[i]    <= dly_from(lfsr_p1, i);
              end else begin
                x_p1[i] <= sat_step(x_p1[i], step_p0);
              end
            end
            default: state_p1[i] <= HOLD;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
    assign bus.x_flat[g*X_W +: X_W]   = x_p1[g];
    assign bus.shape_flat[2*g +: 2]   = shape_p1[g];
  end

  assign bus.active     = active_p1;
  assign bus.spawn      = spawn_p1;
  assign bus.exit_pulse = exit_p1;

endmodule

// File: tb/tb_obstacle_lane_scroller.sv
module tb_obstacle_lane_scroller;

  localparam int          NL      = 3;
  localparam int          XW      = 8;
  localparam int          SW      = 2;
  localparam int          DW      = 3;
  localparam int          XSTART  = 156;
  localparam int          XMIN    = 4;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          RAMP    = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  obstacle_lane_scroller_if #(.NUM_LANES(NL), .X_W(XW), .SPEED_W(SW)) bus ();

  obstacle_lane_scroller #(
    .NUM_LANES(NL), .X_W(XW), .X_START(XSTART), .X_MIN(XMIN),
    .SPEED_W(SW), .DLY_W(DW), .SEED(SEED), .RAMP_COUNT(RAMP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [NL*XW-1:0] x;
    logic [2*NL-1:0]  shape;
    logic [NL-1:0]    act;
    logic [NL-1:0]    spn;
    logic [NL-1:0]    ext;
    logic [SW-1:0]    lvl;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain integers describing each lane's situation.
  bit m_running [NL];
  int m_x       [NL];
  int m_wait    [NL];
  int m_shape   [NL];
  int m_lfsr;
  int m_level;
  int m_exits;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  function automatic int bit_of(input int v, input int k);
    return (v >> k) & 1;
  endfunction

  // Applies one clock's worth of rules to the model and returns the outputs
  // that should be visible just after the next rising edge.
  function automatic exp_t model_step(input bit r, input bit u, input bit p, input int spd);
    exp_t e;
    int   step, nx, rr, exits_now;
    e = '0;
    if (r) begin
      m_lfsr  = SEED;
      m_level = 0;
      m_exits = 0;
      for (int i = 0; i < NL; i++) begin
        m_running[i] = 0;
        m_x[i]       = XSTART;
        m_wait[i]    = i % (1 << DW);
        m_shape[i]   = 0;
      end
    end else begin
      exits_now = 0;
      if (u && !p) begin
        step = spd;
`ifdef OBSTACLE_SPEED_RAMP_EN
        if (m_level > step) step = m_level;
`endif
        step = step + 1;
        for (int i = 0; i < NL; i++) begin
          if (!m_running[i]) begin
            if (m_wait[i] == 0) begin
              m_running[i] = 1;
              m_x[i]       = XSTART;
              m_shape[i]   = bit_of(m_lfsr, (3*i+1) % 16) * 2 + bit_of(m_lfsr, (3*i) % 16);
              e.spn[i]     = 1'b1;
            end else begin
              m_wait[i] = m_wait[i] - 1;
            end
          end else if (m_x[i] <= XMIN) begin
            m_running[i] = 0;
            rr           = (4 * i) % 16;
            m_wait[i]    = (((m_lfsr >> rr) | (m_lfsr << (16 - rr))) & 'hFFFF) % (1 << DW);
            e.ext[i]     = 1'b1;
            exits_now++;
          end else begin
            nx = m_x[i] - step;
            m_x[i] = (nx < XMIN) ? XMIN : nx;
          end
        end
      end
`ifdef OBSTACLE_SPEED_RAMP_EN
      m_exits = m_exits + exits_now;
      if (m_exits >= RAMP) begin
        m_exits = m_exits - RAMP;
        if (m_level < (1 << SW) - 1) m_level++;
      end
`endif
      // Feedback is the parity of the tapped bits 16,14,13,11.
      m_lfsr = ((m_lfsr << 1) | ($countones(m_lfsr & 'hB400) & 1)) & 'hFFFF;
    end
    for (int i = 0; i < NL; i++) begin
      e.x[i*XW +: XW]   = XW'(m_x[i]);
      e.shape[2*i +: 2] = 2'(m_shape[i]);
      e.act[i]          = m_running[i];
    end
    e.lvl = SW'(m_level);
    return e;
  endfunction

  task automatic drive(input bit r, input bit u, input bit p, input int spd);
    @(negedge clk);
    reset      = r;
    bus.update = u;
    bus.pause  = p;
    bus.speed  = SW'(spd);
    exp_q.push_back(model_step(r, u, p, spd));
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are registered, so each rising edge presents the
  // response to the inputs driven before it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("x_flat",     64'(bus.x_flat),     64'(e.x));
        check("shape_flat", 64'(bus.shape_flat), 64'(e.shape));
        check("active",     64'(bus.active),     64'(e.act));
        check("spawn",      64'(bus.spawn),      64'(e.spn));
        check("exit_pulse", 64'(bus.exit_pulse), 64'(e.ext));
        check("level",      64'(bus.level),      64'(e.lvl));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.update = 1'b0;
    bus.pause  = 1'b0;
    bus.speed  = '0;

    // Reset, with an update during reset that must be ignored.
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 3);
    settle();
    check("rst_x",      64'(bus.x_flat), 64'h9C9C9C);
    check("rst_active", 64'(bus.active), 64'h0);
    check("rst_spawn",  64'(bus.spawn),  64'h0);

    // Staggered first spawns and the first step of lane 0.
    drive(0, 1, 0, 3);
    settle();
    check("tick1_spawn",  64'(bus.spawn),          64'b001);
    check("tick1_active", 64'(bus.active),         64'b001);
    check("tick1_x0",     64'(bus.x_flat[7:0]),    64'd156);
    drive(0, 1, 0, 3);
    settle();
    check("tick2_spawn",  64'(bus.spawn),          64'b010);
    check("tick2_x0",     64'(bus.x_flat[7:0]),    64'd152);
    drive(0, 1, 0, 3);
    settle();
    check("tick3_spawn",  64'(bus.spawn),          64'b100);

    // Continuous ticks at speed 3: lane 0 reaches 4 and exits on the 39th.
    for (int i = 0; i < 60; i++) drive(0, 1, 0, 3);

    // Paused frames with update pulsing: nothing may move or pulse.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, $urandom_range(0, 3));
      drive(0, 0, 1, $urandom_range(0, 3));
    end
    settle();
    check("pause_spawn", 64'(bus.spawn),      64'h0);
    check("pause_exit",  64'(bus.exit_pulse), 64'h0);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 2);

    // Random ticks, pauses and speeds.
    for (int i = 0; i < 1500; i++)
      drive(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), $urandom_range(0, 3));

    // Slow scrolling to exercise single-pixel saturation near the edge.
    for (int i = 0; i < 500; i++)
      drive(0, ($urandom_range(0, 7) != 0), 1'b0, ($urandom_range(0, 15) == 0) ? 1 : 0);

    // Reset in mid-scroll.
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 1);
    drive(1, 1, 0, 3);
    settle();
    check("midrst_x",      64'(bus.x_flat),     64'h9C9C9C);
    check("midrst_active", 64'(bus.active),     64'h0);
    check("midrst_spawn",  64'(bus.spawn),      64'h0);
    check("midrst_exit",   64'(bus.exit_pulse), 64'h0);

    for (int i = 0; i < 400; i++)
      drive(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    drive(0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    check("drain", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/obstacle_lane_scroller.md
Name: obstacle_lane_scroller

Overview:
- Parametrised multi-lane obstacle generator for the running-man playfield.
- Each of NUM_LANES lanes carries one obstacle that scrolls leftward at a speed-dependent step on every `update` tick.
- When a lane's obstacle exits at the left edge, the lane idles for a pseudo-random number of ticks, then respawns at the right edge with a new pseudo-random shape.
- Feeds the draw FSM (`x_flat`, `shape_flat`, `active`) and the collision/score logic (`spawn`, `exit_pulse`).

Parameters:
- NUM_LANES, 3, number of independent obstacle lanes (1..8).
- X_W, 8, width of an x coordinate.
- X_START, 156, spawn x coordinate.
- X_MIN, 4, left-edge x; an obstacle at or below this exits on its next tick.
- SPEED_W, 2, speed input width; step = speed+1.
- DLY_W, 3, width of the respawn-delay counter.
- SEED, 16'hACE1, LFSR reset value (must be non-zero).
- RAMP_COUNT, 8, number of exits per speed-level increment (used only with SPEED_RAMP_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active high.
- update  input  1  one-cycle frame tick, synchronous to clk.
- pause  input  1  freezes all lane state.
- speed  input  SPEED_W  requested speed, sampled on update.
- x_flat  output  NUM_LANES*X_W  lane i x coordinate at bits [i*X_W +: X_W].
- shape_flat  output  NUM_LANES*2  lane i shape code at bits [2i +: 2].
- active  output  NUM_LANES  lane i obstacle is on screen.
- spawn  output  NUM_LANES  one-cycle pulse when lane i spawns.
- exit_pulse  output  NUM_LANES  one-cycle pulse when lane i exits.
- level  output  SPEED_W  current ramp level; constant 0 when the feature is compiled out.

Behaviour:
- Clocking and reset:
  - Single clock. All state is updated on the rising edge of `clk`.
  - `reset` has priority over everything else.
  - Reset values: x = X_START, shape = 2'b00, active = 0, spawn = 0, exit_pulse = 0, level = 0, LFSR = SEED, lane i state = HOLD with dly = i mod 2^DLY_W.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle that is not a reset cycle, including while paused.
- Tick gating:
  - A tick is a cycle with update=1 and pause=0.
  - Non-tick cycles hold all lane state. spawn and exit_pulse are 0 on non-tick cycles.
- Per-lane FSM, states HOLD and RUN, evaluated on each tick:
  - HOLD, dly != 0: decrement dly.
  - HOLD, dly == 0: go to RUN. Set x = X_START, active = 1, spawn[i] = 1 for one cycle. Latch shape = {lfsr[(3i+1)%16], lfsr[(3i)%16]}.
  - RUN, x <= X_MIN: go to HOLD. Set active = 0, exit_pulse[i] = 1 for one cycle. Load dly from the low DLY_W bits of lfsr rotated right by 4i. x is held at its last value.
  - RUN, otherwise: x <= (x - step < X_MIN) ? X_MIN : x - step. Evaluate the comparison in X_W+1 bits so it never underflows.
- Step rule:
  - step = eff_speed + 1, where eff_speed = speed when the feature is compiled out.
  - Speed is sampled only on tick cycles; changes between ticks have no effect.
- Latency:
  - Outputs are registered and update one cycle after the tick.
  - shape and x change together, in the same cycle spawn[i] goes high.
- Simultaneous events:
  - Lanes are independent. Any subset may spawn or exit in the same tick.
  - update while reset is asserted is ignored.
  - Reset in mid-scroll returns every lane to its reset state in the next cycle. Pending pulses are cleared.

Optional Feature:
- Macro: OBSTACLE_SPEED_RAMP_EN.
- Defined:
  - A counter of exits (sum of exit_pulse bits per tick) wraps at RAMP_COUNT.
  - Each wrap increments `level`, saturating at 2^SPEED_W-1.
  - eff_speed = max(speed, level).
  - `level` is cleared by reset.
- Undefined:
  - No ramp logic is built.
  - level is tied to 0 and eff_speed = speed.

Test Plan:
- Reset, then first tick (NUM_LANES=3) -> spawn=3'b001, active=3'b001, x0=156, shape0 taken from the LFSR bits of that cycle. Second tick -> spawn=3'b010 and x0 decrements. Third tick -> spawn=3'b100.
- Lane 0 at speed=3 from x=156 -> 152, 148, ..., reaches 4 after 38 ticks. The 39th tick gives exit_pulse[0]=1 and active[0]=0 with x0 held at 4.
- Saturation: lane at x=6 with speed=3 -> x=4, not 2. At x=5 with speed=0 -> x=4. Next tick -> exit.
- pause=1 with update pulsing for 10 ticks -> x, active, dly and shape unchanged, no spawn or exit pulses. Release pause -> scrolling resumes from the held x.
- Reset asserted while lanes are in RUN at x=80 -> next cycle all x=156, active=0, pulses 0, LFSR=16'hACE1.
- With OBSTACLE_SPEED_RAMP_EN, RAMP_COUNT=8, speed=0 -> after the 8th exit level=1 and steps become 2. After enough exits level saturates at 3. Without the macro, level stays 0.
